// File: rtl/boot_stream_arbiter.sv
// Merges the boot manager's flash-protect stream and buffered UART bytes into one
// byte stream for the serial Wishbone master. Protect bytes go first, then UART bytes from the FIFO.
module boot_stream_arbiter #(
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LEVEL_BITS = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  sreset,
  input  logic                  s_axis_protect_tvalid,
  output logic                  s_axis_protect_tready,
  input  logic [7:0]            s_axis_protect_tdata,
  input  logic                  protect_done,
  input  logic                  uart_rx_valid,
  input  logic [7:0]            uart_rx_data,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic [LEVEL_BITS-1:0] fifo_level,
  output logic                  uart_overflow
);

  localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);

  typedef enum logic {
    PROTECT = 1'b0,
    PASS    = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [LEVEL_BITS-1:0] level;
  logic                  overflow;
  logic                  full, empty, push, pop, drop;

  assign full  = (level == LEVEL_BITS'(FIFO_DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (sreset) state <= PROTECT;
    else        state <= state_nxt;
  end

  // Output mux: combinational pass-through while protecting, FIFO head afterwards.
  always_comb begin
    state_nxt             = state;
    m_axis_tvalid         = 1'b0;
    m_axis_tdata          = 8'h00;
    s_axis_protect_tready = 1'b0;
    if (!sreset) begin
      case (state)
        PROTECT: begin
          m_axis_tvalid         = s_axis_protect_tvalid;
          m_axis_tdata          = s_axis_protect_tdata;
          s_axis_protect_tready = m_axis_tready;
          if (protect_done) state_nxt = PASS;
        end
        PASS: begin
          m_axis_tvalid = !empty;
          m_axis_tdata  = mem[rd_ptr];
        end
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign pop  = (state == PASS) && m_axis_tvalid && m_axis_tready;
  assign push = uart_rx_valid && (!full || pop);
  assign drop = uart_rx_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      if (push && !pop)      level <= level + LEVEL_BITS'(1);
      else if (pop && !push) level <= level - LEVEL_BITS'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart_rx_data;
  end

  assign fifo_level    = level;
  assign uart_overflow = overflow;

endmodule

// File: doc/boot_stream_arbiter.md
Name: boot_stream_arbiter

Overview:
- Sits between the boot manager's flash-protect byte stream and the serial Wishbone master's command input.
- While the protect sequence is running, forwards protect bytes only. UART bytes arriving in that window are buffered in a FIFO, not lost.
- Once protection completes, switches permanently to the UART path and drains the FIFO into the master.
- Flags an overflow if the UART outruns the buffer.

Parameters:
- FIFO_DEPTH, 16, UART byte buffer depth in entries; must be a power of 2, at least 2.
- LEVEL_BITS, $clog2(FIFO_DEPTH)+1, width of the fill-level output; derived, not overridden.

Ports:
- clk  input  1  system clock.
- sreset  input  1  synchronous reset, active-high.
- s_axis_protect_tvalid  input  1  protect stream valid.
- s_axis_protect_tready  output  1  protect stream ready.
- s_axis_protect_tdata  input  8  protect stream byte.
- protect_done  input  1  level; high once the last protect beat has handshaken; stays high until reset.
- uart_rx_valid  input  1  single-cycle strobe, one UART byte received; no backpressure.
- uart_rx_data  input  8  received byte, valid with the strobe.
- m_axis_tvalid  output  1  merged stream valid, to the serial master.
- m_axis_tready  input  1  merged stream ready.
- m_axis_tdata  output  8  merged stream byte.
- fifo_level  output  LEVEL_BITS  current FIFO occupancy, 0..FIFO_DEPTH.
- uart_overflow  output  1  sticky; a UART byte was dropped.

Behaviour:
- Reset values while sreset is high: state=PROTECT, FIFO empty, fifo_level=0, uart_overflow=0, m_axis_tvalid=0, s_axis_protect_tready=0.
- Reset mid-operation: the FIFO is flushed and any in-flight byte is discarded.
- States: PROTECT, PASS. No path from PASS back to PROTECT except reset.
- PROTECT:
  - Combinational pass-through: m_axis_tvalid=s_axis_protect_tvalid, m_axis_tdata=s_axis_protect_tdata, s_axis_protect_tready=m_axis_tready.
  - FIFO is never popped.
- PROTECT -> PASS: on the first clock edge with protect_done=1.
  - If protect_done is high on the first cycle after reset (unprotected/upgrade mode), PASS is entered after one PROTECT cycle; no protect beats are required.
- PASS:
  - s_axis_protect_tready=0; protect-side tvalid is ignored.
  - m_axis_tvalid = FIFO non-empty; m_axis_tdata = FIFO head (first-word fall-through).
  - Pop on m_axis_tvalid && m_axis_tready.
- FIFO push:
  - Every uart_rx_valid pushes in either state. A byte written at edge N is visible at the FIFO head, and in PASS on m_axis, from cycle N+1 (one-cycle latency).
  - Ordering is strictly first-in-first-out.
- Full, no pop in the same cycle: the incoming byte is dropped, uart_overflow sets, FIFO contents are unchanged.
- Full, with a pop in the same cycle: the push is accepted, level is unchanged, no overflow.
- Empty, push and pop in the same cycle: cannot happen, because an empty FIFO presents tvalid=0. Level goes 0->1.
- fifo_level: +1 on push-only, -1 on pop-only, unchanged on both or neither. Never exceeds FIFO_DEPTH; never underflows.
- Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_level.
- m_axis_tvalid, once asserted in PASS, holds with stable tdata until handshake.
- uart_overflow clears only on sreset.

Test Plan:
- Reset, then protect stream sends 0x01,0x02,0x01 with m_axis_tready=1 and no UART traffic; raise protect_done -> m_axis sees 0x01,0x02,0x01 in order, then tvalid=0 in PASS, fifo_level=0.
- During PROTECT, strobe UART bytes 0xA5,0x5A,0x3C while protect beats flow -> m_axis carries only protect bytes and fifo_level=3; after protect_done, m_axis emits 0xA5,0x5A,0x3C in order and level returns to 0.
- FIFO_DEPTH=16, PROTECT held, 17 UART strobes -> fifo_level=16, uart_overflow=1; after PASS the 16 emitted bytes are the first 16 sent and the 17th is absent.
- Full FIFO in PASS, m_axis_tready=1 with a simultaneous UART strobe 0x77 -> head pops, 0x77 is accepted, level stays 16, uart_overflow remains 0.
- protect_done=1 from the first post-reset cycle; UART bytes 0x10,0x20 arrive with m_axis_tready toggling 1,0,1 -> tdata stable while stalled, both bytes delivered, s_axis_protect_tready held 0 throughout PASS.
- Assert sreset mid-drain with level=5 and uart_overflow=1 -> next cycle fifo_level=0, uart_overflow=0, m_axis_tvalid=0, state=PROTECT.
